// File: rtl/morse_number_encoder.sv
// Keys out decimal digits 0..9 as five-symbol Morse characters, including the trailing character gap.
// Defining MORSE_ENC_ERR_EN rejects codes 10..15 with an err pulse. Without it, those codes fold modulo 10.
module morse_number_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] digit,
    output logic       morse_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = (3 * UNIT_CYCLES > 1) ? $clog2(3 * UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, TAIL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sym;
    logic [3:0]       code;
    logic [CNT_W-1:0] mark_last;
    logic             accept;

    function automatic logic [3:0] fold_digit(input logic [3:0] d);
        return (d > 4'd9) ? d - 4'd10 : d;
    endfunction

    // Digits 1..5 start with dots, and digits 6..9 start with dashes. Digit 0 is all dashes.
    function automatic logic is_dash(input logic [3:0] d, input logic [2:0] idx);
        if (d == 4'd0)
            return 1'b1;
        else if (d <= 4'd5)
            return {1'b0, idx} >= d;
        else
            return {1'b0, idx} < (d - 4'd5);
    endfunction

`ifdef MORSE_ENC_ERR_EN
    assign accept = start && (digit <= 4'd9);
`else
    assign accept = start;
`endif

    always_comb begin
        mark_last = UNIT_LAST;
        if (is_dash(code, sym))
            mark_last = DASH_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sym       <= '0;
            code      <= '0;
            morse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MORSE_ENC_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MORSE_ENC_ERR_EN
            err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= MARK;
                        code      <= fold_digit(digit);
                        cnt       <= '0;
                        sym       <= '0;
                        morse_out <= 1'b1;
                        busy      <= 1'b1;
                    end
`ifdef MORSE_ENC_ERR_EN
                    else if (start) begin
                        err <= 1'b1;
                    end
`endif
                end
                MARK: begin
                    if (cnt == mark_last) begin
                        cnt       <= '0;
                        morse_out <= 1'b0;
                        state     <= (sym == 3'd4) ? TAIL : SPACE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SPACE: begin
                    if (cnt == UNIT_LAST) begin
                        cnt       <= '0;
                        sym       <= sym + 1'b1;
                        morse_out <= 1'b1;
                        state     <= MARK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TAIL: begin
                    // The done cycle is also an idle cycle, so a start here chains the next character directly.
                    if (cnt == DASH_LAST) begin
                        cnt   <= '0;
                        sym   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MORSE_ENC_ERR_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_morse_number_encoder.sv
// Bench for morse_number_encoder with UNIT_CYCLES=2. Captured waveforms are compared against a symbol-level model.
module tb_morse_number_encoder;

    localparam int U = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] digit;
    logic       morse_out, busy, done, err;

    int total = 0;
    int bad   = 0;

    bit wave[$];
    bit exp_q[$];
    int done_in, err_in, timed_out;
    logic done_end;

    typedef struct {
        logic [3:0] d;
        int         exp_busy;
        logic [4:0] exp_mask;
    } vec_t;

    vec_t tbl[8];

    morse_number_encoder #(.UNIT_CYCLES(U)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .digit(digit),
        .morse_out(morse_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Builds the expected morse_out sequence from the symbols of each digit and the unit timing.
    task automatic build_model(input int d);
        string syms;
        int f;
        f = d % 10;
        syms = "";
        if (f == 0) syms = "-----";
        else if (f <= 5) begin
            for (int i = 0; i < f; i++) syms = {syms, "."};
            for (int i = f; i < 5; i++) syms = {syms, "-"};
        end else begin
            for (int i = 0; i < f - 5; i++) syms = {syms, "-"};
            for (int i = f - 5; i < 5; i++) syms = {syms, "."};
        end
        exp_q.delete();
        for (int s = 0; s < 5; s++) begin
            int len;
            len = (syms[s] == "-") ? 3 * U : U;
            for (int k = 0; k < len; k++) exp_q.push_back(1'b1);
            if (s < 4) for (int k = 0; k < U; k++) exp_q.push_back(1'b0);
        end
        for (int k = 0; k < 3 * U; k++) exp_q.push_back(1'b0);
    endtask

    // Called at the negedge right after the accepting edge; returns at the first negedge with busy low.
    task automatic capture();
        int n;
        wave.delete();
        done_in = 0;
        err_in = 0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            wave.push_back(morse_out);
            if (done !== 1'b0) done_in++;
            if (err !== 1'b0) err_in++;
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 400);
        done_end = done;
    endtask

    task automatic compare_char(input string name, input int d);
        int mism;
        build_model(d);
        check({name, "_timeout"}, timed_out, 0);
        check({name, "_busy_len"}, wave.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wave.size() || wave[i] != exp_q[i]) mism++;
        check({name, "_wave_mismatch_cycles"}, mism, 0);
        check({name, "_done_early"}, done_in, 0);
        check({name, "_done_end"}, done_end, 1);
        check({name, "_err"}, err_in, 0);
    endtask

    task automatic measure_mask(output logic [4:0] mask, output int runs);
        int run;
        mask = '0;
        runs = 0;
        run = 0;
        for (int i = 0; i <= wave.size(); i++) begin
            if (i < wave.size() && wave[i]) run++;
            else if (run > 0) begin
                if (runs < 5 && run == 3 * U) mask[runs] = 1'b1;
                runs++;
                run = 0;
            end
        end
    endtask

    task automatic send(input logic [3:0] d);
        start = 1'b1;
        digit = d;
        @(negedge clk);
        start = 1'b0;
        capture();
    endtask

    initial begin
        logic [4:0] mask;
        int runs;

        tbl[0] = '{4'd5,  24, 5'b00000};
        tbl[1] = '{4'd0,  44, 5'b11111};
        tbl[2] = '{4'd6,  28, 5'b00001};
        tbl[3] = '{4'd2,  36, 5'b11100};
        tbl[4] = '{4'd9,  40, 5'b01111};
        tbl[5] = '{4'd1,  40, 5'b11110};
        tbl[6] = '{4'd4,  28, 5'b10000};
`ifdef MORSE_ENC_ERR_EN
        tbl[7] = '{4'd3,  32, 5'b11000};
`else
        tbl[7] = '{4'd12, 36, 5'b11100};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        digit = 4'd0;
        #12;
        check("rst_morse_out", morse_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("tbl_d%0d", tbl[i].d);
            send(tbl[i].d);
            compare_char(nm, tbl[i].d);
            check({nm, "_busy_table"}, wave.size(), tbl[i].exp_busy);
            measure_mask(mask, runs);
            check({nm, "_marks"}, runs, 5);
            check({nm, "_dash_mask"}, mask, tbl[i].exp_mask);
            @(negedge clk);
            check({nm, "_done_one_cycle"}, done, 0);
        end

        for (int r = 0; r < 10; r++) begin
            logic [3:0] d;
`ifdef MORSE_ENC_ERR_EN
            d = 4'($urandom_range(0, 9));
`else
            d = 4'($urandom_range(0, 15));
`endif
            send(d);
            compare_char($sformatf("rand%0d_d%0d", r, d), d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-to-back: start stays high and digit changes while busy, so the second character uses the done-cycle value.
        start = 1'b1;
        digit = 4'd3;
        @(negedge clk);
        digit = 4'd7;
        capture();
        compare_char("b2b_first", 3);
        check("b2b_done_busy_low", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_immediate", morse_out, 1);
        capture();
        compare_char("b2b_second", 7);
        @(negedge clk);

        // Reset during the third symbol of digit 9.
        start = 1'b1;
        digit = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_pre_reset_mark", morse_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_morse_out", morse_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        done_in = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) done_in++;
        end
        check("mid_rst_no_done", done_in, 0);
        rst_n = 1'b1;
        send(4'd1);
        compare_char("post_rst_d1", 1);
        check("post_rst_busy40", wave.size(), 40);
        @(negedge clk);

`ifdef MORSE_ENC_ERR_EN
        start = 1'b1;
        digit = 4'd12;
        @(negedge clk);
        start = 1'b0;
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_morse_out", morse_out, 0);
        @(negedge clk);
        check("rej_err_one_cycle", err, 0);
        check("rej_busy_after", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
